// File: rtl/secded_pkg.sv
// Shared types and helpers for the extended-Hamming (SECDED) stream decoder.
// Helpers work on a 64-bit maximum codeword so they serve any DATA_W up to 57.
package secded_pkg;

    localparam int MAX_CODE_W = 64;
    localparam int MAX_DATA_W = 57;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_SINGLE = 2'd1,
        ERR_DOUBLE = 2'd2
    } err_class_t;

    // Smallest r with 2^r >= data_w + r + 1; scanning downward leaves the smallest hit.
    function automatic int par_bits(input int data_w);
        int r;
        r = 32'sd7;
        for (int k = 7; k >= 1; k--) begin
            if ((32'sd1 << k) >= data_w + k + 32'sd1) begin
                r = k;
            end
        end
        return r;
    endfunction

    function automatic logic is_pow2(input int idx);
        return (idx > 32'sd0) && ((idx & (idx - 32'sd1)) == 32'sd0);
    endfunction

    function automatic logic [MAX_DATA_W-1:0] extract_data(input logic [MAX_CODE_W-1:0] code,
                                                           input int code_w);
        logic [MAX_DATA_W-1:0] d;
        int k;
        d = '0;
        k = 32'sd0;
        for (int i = 1; i < MAX_CODE_W; i++) begin
            if ((i < code_w) && !is_pow2(i)) begin
                d[k] = code[i];
                k++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome, overall parity and error classification of one codeword.
module secded_syndrome
    import secded_pkg::*;
#(
    parameter int CODE_W = 13,
    parameter int PAR_W  = 4
) (
    input  logic [CODE_W-1:0] code,
    output logic [PAR_W-1:0]  syndrome,
    output logic              parity,
    output err_class_t        err_class
);

    logic [PAR_W-1:0] syn_s;

    // XOR together the indices of every set bit above the overall-parity bit
    always_comb begin
        syn_s = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (code[i]) begin
                syn_s = syn_s ^ PAR_W'(i);
            end else begin
                syn_s = syn_s;
            end
        end
    end

    assign parity   = ^code;
    assign syndrome = syn_s;

    // Odd parity with an out-of-range syndrome cannot be a single flip, so it is uncorrectable
    always_comb begin
        if ((syn_s == '0) && !parity) begin
            err_class = ERR_NONE;
        end else if (parity && (int'(syn_s) <= CODE_W - 1)) begin
            err_class = ERR_SINGLE;
        end else begin
            err_class = ERR_DOUBLE;
        end
    end

endmodule

// File: rtl/secded_stream_decoder.sv
// Two-stage SECDED decoder on a valid/ready stream with saturating error counters
// and a sticky capture of the first delivered error.
module secded_stream_decoder
    import secded_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    parameter int PAR_W  = par_bits(DATA_W),
    parameter int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              correct_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_1bit_err,
    output logic              out_2bit_err,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count,
    output logic              first_err_valid,
    output logic [PAR_W-1:0]  first_err_syndrome
);

    logic [PAR_W-1:0]  syn_s;
    logic              par_s;
    err_class_t        class_s;

    logic              s1_valid_r;
    logic [CODE_W-1:0] s1_code_r;
    logic [PAR_W-1:0]  s1_syn_r;
    logic              s1_par_r;
    err_class_t        s1_class_r;
    logic              s1_cen_r;

    logic              out_valid_r;
    logic [CODE_W-1:0] out_code_r;
    logic [DATA_W-1:0] out_data_r;
    logic [PAR_W-1:0]  out_syn_r;
    logic              out_1bit_r;
    logic              out_2bit_r;

    logic [CNT_W-1:0]  corr_cnt_r;
    logic [CNT_W-1:0]  uncorr_cnt_r;
    logic              first_valid_r;
    logic [PAR_W-1:0]  first_syn_r;

    logic              adv1_s;
    logic              adv2_s;
    logic              out_hs_s;
    logic [CODE_W-1:0] fixed_s;
    logic [DATA_W-1:0] data_s;
    logic              flag1_s;
    logic              flag2_s;

    secded_syndrome #(.CODE_W(CODE_W), .PAR_W(PAR_W)) u_syndrome (
        .code      (in_code),
        .syndrome  (syn_s),
        .parity    (par_s),
        .err_class (class_s)
    );

    assign adv2_s   = !out_valid_r || out_ready;
    assign adv1_s   = !s1_valid_r || adv2_s;
    assign in_ready = adv1_s;
    assign out_hs_s = out_valid_r && out_ready;

    // Stage 1: capture the word with its syndrome, parity, class and correct_en
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_code_r  <= '0;
            s1_syn_r   <= '0;
            s1_par_r   <= 1'b0;
            s1_class_r <= ERR_NONE;
            s1_cen_r   <= 1'b0;
        end else if (adv1_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_code_r  <= in_code;
                s1_syn_r   <= syn_s;
                s1_par_r   <= par_s;
                s1_class_r <= class_s;
                s1_cen_r   <= correct_en;
            end
        end
    end

    // Flip the indicated bit only for a single error with correction enabled
    always_comb begin
        if (s1_cen_r && s1_par_r && (s1_class_r == ERR_SINGLE)) begin
            fixed_s = s1_code_r ^ (CODE_W'(1'b1) << s1_syn_r);
        end else begin
            fixed_s = s1_code_r;
        end
        data_s = DATA_W'(extract_data(MAX_CODE_W'(fixed_s), CODE_W));
    end

    // Decode the registered class into the two output flags
    always_comb begin
        case (s1_class_r)
            ERR_NONE:   begin flag1_s = 1'b0; flag2_s = 1'b0; end
            ERR_SINGLE: begin flag1_s = 1'b1; flag2_s = 1'b0; end
            ERR_DOUBLE: begin flag1_s = 1'b0; flag2_s = 1'b1; end
            default:    begin flag1_s = 1'b0; flag2_s = 1'b1; end
        endcase
    end

    // Stage 2: output register, frozen while downstream stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_code_r  <= '0;
            out_data_r  <= '0;
            out_syn_r   <= '0;
            out_1bit_r  <= 1'b0;
            out_2bit_r  <= 1'b0;
        end else if (adv2_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_code_r <= fixed_s;
                out_data_r <= data_s;
                out_syn_r  <= s1_syn_r;
                out_1bit_r <= flag1_s;
                out_2bit_r <= flag2_s;
            end
        end
    end

    // Error statistics count only delivered words; clear beats a same-cycle event
    always_ff @(posedge clock) begin
        if (reset || cnt_clear) begin
            corr_cnt_r    <= '0;
            uncorr_cnt_r  <= '0;
            first_valid_r <= 1'b0;
            first_syn_r   <= '0;
        end else if (out_hs_s) begin
            if (out_1bit_r && (corr_cnt_r != '1)) begin
                corr_cnt_r <= corr_cnt_r + CNT_W'(1'b1);
            end
            if (out_2bit_r && (uncorr_cnt_r != '1)) begin
                uncorr_cnt_r <= uncorr_cnt_r + CNT_W'(1'b1);
            end
            if ((out_1bit_r || out_2bit_r) && !first_valid_r) begin
                first_valid_r <= 1'b1;
                first_syn_r   <= out_syn_r;
            end
        end
    end

    assign out_valid          = out_valid_r;
    assign out_code           = out_code_r;
    assign out_data           = out_data_r;
    assign out_syndrome       = out_syn_r;
    assign out_1bit_err       = out_1bit_r;
    assign out_2bit_err       = out_2bit_r;
    assign corr_count         = corr_cnt_r;
    assign uncorr_count       = uncorr_cnt_r;
    assign first_err_valid    = first_valid_r;
    assign first_err_syndrome = first_syn_r;

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Directed bench for secded_stream_decoder at DATA_W=8 with 2-bit counters.
module tb_secded_stream_decoder;

    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, correct_en, out_valid, out_ready;
    logic [12:0] in_code, out_code;
    logic [7:0]  out_data;
    logic [3:0]  out_syndrome, first_err_syndrome;
    logic        out_1bit_err, out_2bit_err, cnt_clear, first_err_valid;
    logic [1:0]  corr_count, uncorr_count;

    int applied = 0;
    int miscompares = 0;

    secded_stream_decoder #(.DATA_W(8), .CNT_W(2)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .correct_en(correct_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_code(out_code), .out_data(out_data),
        .out_syndrome(out_syndrome), .out_1bit_err(out_1bit_err),
        .out_2bit_err(out_2bit_err), .cnt_clear(cnt_clear), .corr_count(corr_count),
        .uncorr_count(uncorr_count), .first_err_valid(first_err_valid),
        .first_err_syndrome(first_err_syndrome)
    );

    always #5 clock = ~clock;

    // Reference encoder: data at 3,5,6,7,9,10,11,12; parity k covers indices with bit k set
    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] c;
        c = 13'h0000;
        c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
        c[9] = d[4]; c[10] = d[5]; c[11] = d[6]; c[12] = d[7];
        c[1] = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
        c[2] = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
        c[4] = c[5] ^ c[6] ^ c[7] ^ c[12];
        c[8] = c[9] ^ c[10] ^ c[11] ^ c[12];
        c[0] = ^c[12:1];
        return c;
    endfunction

    // Present one word with out_ready high; return at the negedge where out_valid is seen
    task automatic send_one(input logic [12:0] code, input logic cen, output int lat);
        int n;
        @(negedge clock);
        in_valid = 1'b1; in_code = code; correct_en = cen; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; correct_en = ~cen;
        n = 0;
        while (!out_valid && n < 8) begin
            @(negedge clock);
            n++;
        end
        lat = n + 1;
        applied++;
        if (!out_valid) begin
            miscompares++;
            $display("FAIL send_timeout code=%h: out_valid never rose", code);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_code = 13'h0000; correct_en = 1'b1;
        out_ready = 1'b0; cnt_clear = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        applied++;
        if ({out_valid, in_ready, corr_count, uncorr_count, first_err_valid} !== {1'b0, 1'b1, 2'd0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_ctrl got v=%b rdy=%b cc=%0d uc=%0d fe=%b", out_valid, in_ready, corr_count, uncorr_count, first_err_valid);
        end
        applied++;
        if ({out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err} !== 27'h0) begin
            miscompares++;
            $display("FAIL reset_data got code=%h data=%h syn=%h", out_code, out_data, out_syndrome);
        end
    endtask

    task automatic test_clean();
        int lat;
        send_one(13'h1EEE, 1'b1, lat);
        applied++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL latency got %0d want 2", lat);
        end
        applied++;
        if ({out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err} !== {13'h1EEE, 8'hFF, 4'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL clean got code=%h data=%h syn=%h f1=%b f2=%b want 1eee ff 0 0 0", out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err);
        end
        @(negedge clock);
        applied++;
        if ({corr_count, uncorr_count, first_err_valid} !== {2'd0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL clean_counters got cc=%0d uc=%0d fe=%b want 0 0 0", corr_count, uncorr_count, first_err_valid);
        end
    endtask

    task automatic test_errors();
        int lat;
        send_one(13'h1ECE, 1'b1, lat);
        applied++;
        if ({out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err} !== {13'h1EEE, 8'hFF, 4'h5, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL single_fix got code=%h data=%h syn=%h f1=%b f2=%b", out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err);
        end
        @(negedge clock);
        applied++;
        if ({corr_count, uncorr_count, first_err_valid, first_err_syndrome} !== {2'd1, 2'd0, 1'b1, 4'h5}) begin
            miscompares++;
            $display("FAIL single_cnt got cc=%0d uc=%0d fe=%b fs=%h want 1 0 1 5", corr_count, uncorr_count, first_err_valid, first_err_syndrome);
        end
        send_one(13'h1E8E, 1'b1, lat);
        applied++;
        if ({out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err} !== {13'h1E8E, 8'hF9, 4'h3, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL double got code=%h data=%h syn=%h f1=%b f2=%b", out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err);
        end
        @(negedge clock);
        applied++;
        if ({corr_count, uncorr_count, first_err_syndrome} !== {2'd1, 2'd1, 4'h5}) begin
            miscompares++;
            $display("FAIL double_cnt got cc=%0d uc=%0d fs=%h want 1 1 5", corr_count, uncorr_count, first_err_syndrome);
        end
        send_one(13'h1EEF, 1'b0, lat);
        applied++;
        if ({out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err} !== {13'h1EEF, 8'hFF, 4'h0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL detect_only got code=%h data=%h syn=%h f1=%b f2=%b", out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err);
        end
        @(negedge clock);
        send_one(13'h0EE8, 1'b1, lat);
        applied++;
        if ({out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err} !== {13'h0EE8, 8'h7F, 4'hF, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL syn_out_of_range got code=%h data=%h syn=%h f1=%b f2=%b", out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err);
        end
        @(negedge clock);
        send_one(13'h1EEF, 1'b1, lat);
        applied++;
        if ({out_code, out_syndrome, out_1bit_err} !== {13'h1EEE, 4'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL fix_bit0 got code=%h syn=%h f1=%b want 1eee 0 1", out_code, out_syndrome, out_1bit_err);
        end
        @(negedge clock);
        applied++;
        if ({corr_count, uncorr_count} !== {2'd3, 2'd2}) begin
            miscompares++;
            $display("FAIL err_totals got cc=%0d uc=%0d want 3 2", corr_count, uncorr_count);
        end
    endtask

    task automatic test_counters();
        int lat;
        logic [12:0] codes [5];
        codes = '{13'h1ECE, 13'h1EEF, 13'h1EEC, 13'h1EEA, 13'h0EEE};
        @(negedge clock);
        cnt_clear = 1'b1;
        @(negedge clock);
        cnt_clear = 1'b0;
        applied++;
        if ({corr_count, uncorr_count, first_err_valid} !== {2'd0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL clear got cc=%0d uc=%0d fe=%b want 0 0 0", corr_count, uncorr_count, first_err_valid);
        end
        for (int i = 0; i < 5; i++) begin
            send_one(codes[i], 1'b1, lat);
            @(negedge clock);
        end
        applied++;
        if ({corr_count, uncorr_count, first_err_valid, first_err_syndrome} !== {2'd3, 2'd0, 1'b1, 4'h5}) begin
            miscompares++;
            $display("FAIL saturate got cc=%0d uc=%0d fe=%b fs=%h want 3 0 1 5", corr_count, uncorr_count, first_err_valid, first_err_syndrome);
        end
        send_one(13'h1EE6, 1'b1, lat);
        cnt_clear = 1'b1;
        @(negedge clock);
        cnt_clear = 1'b0;
        applied++;
        if ({corr_count, first_err_valid} !== {2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL clear_wins got cc=%0d fe=%b want 0 0", corr_count, first_err_valid);
        end
        send_one(13'h1EE6, 1'b1, lat);
        @(negedge clock);
        applied++;
        if ({corr_count, first_err_valid, first_err_syndrome} !== {2'd1, 1'b1, 4'h3}) begin
            miscompares++;
            $display("FAIL after_clear got cc=%0d fe=%b fs=%h want 1 1 3", corr_count, first_err_valid, first_err_syndrome);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  sd [8];
        int          sf [8];
        logic [12:0] word;
        logic [26:0] held, got, want;
        int          sent, recv, cyc;
        logic        stalled;
        sd = '{8'h00, 8'hA5, 8'h3C, 8'hFF, 8'h5A, 8'h81, 8'h7E, 8'h12};
        sf = '{-1, 3, -1, 0, 12, -1, 8, -1};
        sent = 0; recv = 0; cyc = 0; stalled = 1'b0; held = 27'h0;
        correct_en = 1'b1;
        while (recv < 8 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 8) begin
                word = enc(sd[sent]);
                if (sf[sent] >= 0) word[sf[sent]] = ~word[sf[sent]];
                in_valid = 1'b1; in_code = word;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            got = {out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err};
            if (stalled) begin
                applied++;
                if (!out_valid || got !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold word=%0d got v=%b %h want 1 %h", recv, out_valid, got, held);
                end
            end
            if (out_valid && out_ready) begin
                want = {enc(sd[recv]), sd[recv], (sf[recv] >= 0) ? 4'(sf[recv]) : 4'h0, sf[recv] >= 0, 1'b0};
                applied++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL stream word=%0d got %h want %h", recv, got, want);
                end
                recv++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                held = got;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        applied++;
        if (recv != 8 || sent != 8) begin
            miscompares++;
            $display("FAIL stream_count got sent=%0d recv=%0d want 8 8", sent, recv);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            applied++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_dup cycle=%0d got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clock);
        in_valid = 1'b1; in_code = 13'h1ECE; correct_en = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        in_code = 13'h1E8E;
        @(negedge clock);
        in_valid = 1'b0;
        applied++;
        if ({out_valid, in_ready} !== {1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL full_pipe got v=%b rdy=%b want 1 0", out_valid, in_ready);
        end
        reset = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        applied++;
        if ({out_valid, in_ready, corr_count, uncorr_count, first_err_valid, out_code} !== {1'b1 == 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 13'h0000}) begin
            miscompares++;
            $display("FAIL mid_reset got v=%b rdy=%b cc=%0d uc=%0d fe=%b code=%h", out_valid, in_ready, corr_count, uncorr_count, first_err_valid, out_code);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            applied++;
            if ({out_valid, corr_count, uncorr_count} !== {1'b0, 2'd0, 2'd0}) begin
                miscompares++;
                $display("FAIL mid_reset_flush cycle=%0d got v=%b cc=%0d uc=%0d", i, out_valid, corr_count, uncorr_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_errors();
        test_counters();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/secded_stream_decoder.md
Name: secded_stream_decoder

Overview:
Parametrised, pipelined SECDED (extended Hamming) decoder for a valid/ready stream of codewords. It generalises the 8-bit-data, 13-bit-code decoder to any data width, and adds:
- a detect-only mode
- output backpressure
- saturating error counters
- a sticky first-error capture register
It sits between a code source (switch bank, memory read port) and downstream consumers or display logic.

Parameters:
DATA_W, 8, data bits per codeword (1..57).
PAR_W, derived, Hamming parity bits: smallest r with 2^r >= DATA_W+r+1 (4 for DATA_W=8).
CODE_W, derived, DATA_W+PAR_W+1 (13 for DATA_W=8).
CNT_W, 16, width of each saturating error counter.

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  in_code is valid
in_ready  output  1  block accepts in_code this cycle
in_code  input  CODE_W  received codeword
correct_en  input  1  1 = correct single errors; 0 = detect only, data passed raw
out_valid  output  1  outputs below are valid
out_ready  input  1  downstream accepts this cycle
out_code  output  CODE_W  corrected (or raw, if detect-only) codeword
out_data  output  DATA_W  data extracted from out_code
out_syndrome  output  PAR_W  Hamming syndrome of in_code
out_1bit_err  output  1  single-bit error detected
out_2bit_err  output  1  uncorrectable error detected
cnt_clear  input  1  synchronous clear of counters and capture
corr_count  output  CNT_W  saturating count of single errors delivered
uncorr_count  output  CNT_W  saturating count of uncorrectable errors delivered
first_err_valid  output  1  sticky: an error has been delivered since reset/clear
first_err_syndrome  output  PAR_W  syndrome of first delivered error

Behaviour:
Code layout:
- Bit 0 is overall parity (XOR of all CODE_W bits is 0 when error-free).
- Bit 2^k is parity bit k.
- Data bits fill the remaining positions in ascending order, data LSB at the lowest position.
- DATA_W=8: out_data = {c[12],c[11],c[10],c[9],c[7],c[6],c[5],c[3]}.

Syndrome and classification:
- syndrome = XOR of the indices of all set bits in positions 1..CODE_W-1.
- p = XOR of all CODE_W bits.
- s==0, p==0: no error.
- p==1 and s<=CODE_W-1: single error at position s; s==0 means bit 0 itself.
- p==0 and s!=0: double error (uncorrectable).
- p==1 and s>CODE_W-1: uncorrectable (out_2bit_err=1).

Correction:
- With correct_en=1 on a single error, flip bit s in out_code.
- Otherwise out_code = in_code.
- Flags and syndrome are reported regardless of correct_en.
- correct_en is sampled with the word at input handshake.

Pipeline:
- Two stages: S1 registers the code, syndrome, parity and correct_en; S2 registers the corrected code and flags.
- Latency is 2 cycles from input handshake to out_valid when out_ready is held at 1.
- Throughput is 1 word/cycle.
- adv2 = !out_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1.
- in_ready is purely combinational from state and out_ready; it does not depend on in_valid.
- While out_valid=1 and out_ready=0, all out_* outputs hold stable.
- No word is lost or duplicated under any valid/ready pattern.

Counters:
- Counters increment on an output handshake (out_valid & out_ready) carrying the matching flag.
- Counters saturate at 2^CNT_W-1.
- cnt_clear wins over a same-cycle increment: that event is dropped.
- first_err_* loads on the first error handshake after reset/clear, then holds until cnt_clear or reset.

Reset:
- Clears s1_valid, out_valid, counters and first_err_valid.
- All data outputs go to 0. in_ready=1 the cycle after reset.
- Reset mid-stream discards in-flight words without counting them.

Decomposition:
- Package secded_pkg holds:
  - function par_bits(DATA_W) computing PAR_W;
  - functions extract_data(code) and is_pow2(idx);
  - typedef enum logic [1:0] err_class_t {ERR_NONE, ERR_SINGLE, ERR_DOUBLE}.
- One combinational sub-module, secded_syndrome, computes syndrome, p and err_class_t from a codeword; it is reusable by a future encoder check.
- The pipeline, handshake and counters live in the top module.

Test Plan:
- DATA_W=8, in_code=13'h1EEE, out_ready=1 -> after 2 cycles out_data=8'hFF, syndrome=0, both flags 0, counters 0.
- in_code=13'h1ECE (bit 5 flipped), correct_en=1 -> out_code=13'h1EEE, out_data=8'hFF, syndrome=5, out_1bit_err=1, corr_count=1, first_err_syndrome=5.
- in_code=13'h1E8E (bits 5, 6) -> syndrome=3, out_2bit_err=1, out_code=13'h1E8E, uncorr_count=1; same word with correct_en=0 and 13'h1EEF -> out_code unchanged, out_1bit_err=1, syndrome=0.
- Stream 8 words with random out_ready (about 50%) -> output order and values match input, no drops or duplicates, outputs stable while stalled.
- CNT_W=2, 5 single-error words -> corr_count saturates at 3; cnt_clear asserted with a 6th error handshake -> counter reads 0, first_err_valid=0.
- Reset asserted with 2 words in flight -> out_valid=0 next cycle, counters 0, in_ready=1.
